max_pool_layer: RTL and testbench

MAX_POOL_LAYER -- requirements
Module: max_pool_layer

---
 rtl/max_pool_layer_if.sv | 14 +
 rtl/max_pool_layer.sv | 69 ++++++
 tb/tb_max_pool_layer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/max_pool_layer_if.sv
// max_pool_layer_if: pixel stream bus between a producer and the max pool layer
// Signals: input_data/input_valid carry incoming pixels, output_data/valid carry
// pooled pixels back out. Modports: master = upstream side, slave = pooling layer.
interface max_pool_layer_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 5
);
  logic [CHANNELS*WIDTH-1:0] input_data;
  logic                      input_valid;
  logic [CHANNELS*WIDTH-1:0] output_data;
  logic                      valid;
  modport master (output input_data, input_valid, input output_data, valid);
  modport slave  (input input_data, input_valid, output output_data, valid);
endinterface

// File: rtl/max_pool_layer.sv
// max_pool_layer: 2x2 stride-2 signed max pooling over a raster-order pixel stream
// Ports: clk, rst (async, active-high), clk_en (freezes all state when low),
// bus (slave): input_data/input_valid in, output_data/valid (one-cycle pulse) out.
// Optional: define MAX_POOL_RELU_EN to clamp negative pooled channels to zero.
module max_pool_layer #(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 5,
  parameter int IMAGE_WIDTH  = 15,
  parameter int IMAGE_HEIGHT = 7
) (
  input logic             clk,
  input logic             rst,
  input logic             clk_en,
  max_pool_layer_if.slave bus
);
  localparam int DW = CHANNELS * WIDTH;
  localparam int CW = IMAGE_WIDTH > 1 ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = IMAGE_HEIGHT > 1 ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int LB = IMAGE_WIDTH / 2 > 0 ? IMAGE_WIDTH / 2 : 1;
  localparam int LW = LB > 1 ? $clog2(LB) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] hold, pair, pooled, out_q;
  logic [DW-1:0] linebuf [LB];
  logic [LW-1:0] idx;
  logic          valid_q, accept, col_last;
  assign accept   = clk_en && bus.input_valid;
  assign col_last = col == CW'(IMAGE_WIDTH - 1);
  assign idx      = LW'(col >> 1);
  // A trailing odd column always lands on an even col and a trailing odd row on an
  // even row, so neither ever reaches the output and needs no special handling.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [WIDTH-1:0] h, x, l, p, m;
    assign h = hold[c*WIDTH +: WIDTH];
    assign x = bus.input_data[c*WIDTH +: WIDTH];
    assign l = linebuf[idx][c*WIDTH +: WIDTH];
    assign p = h > x ? h : x;
    assign m = l > p ? l : p;
    assign pair[c*WIDTH +: WIDTH] = p;
`ifdef MAX_POOL_RELU_EN
    assign pooled[c*WIDTH +: WIDTH] = m[WIDTH-1] ? '0 : m;
`else
    assign pooled[c*WIDTH +: WIDTH] = m;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      hold    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (clk_en) begin
      valid_q <= accept && col[0] && row[0];
      if (accept) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row == RW'(IMAGE_HEIGHT - 1) ? '0 : row + 1'b1;
        if (!col[0]) hold <= bus.input_data;
        if (col[0] && row[0]) out_q <= pooled;
      end
    end
  end
  // Every entry is rewritten on the even row before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) linebuf[idx] <= pair;
  end
  assign bus.output_data = out_q;
  assign bus.valid       = valid_q;
endmodule

// File: tb/tb_max_pool_layer.sv
// tb_max_pool_layer: scoreboard bench for max_pool_layer against a frame-level reference
module tb_max_pool_layer;
  localparam int W  = 16;
  localparam int C  = 5;
  localparam int IW = 15;
  localparam int IH = 7;
  localparam int DW = W * C;
  typedef logic [DW-1:0] px_t;

  logic clk, rst, clk_en;
  px_t  q[$];
  int   cmp = 0, bad = 0, popped = 0;
  logic en_last, pv;
  px_t  po;

  max_pool_layer_if #(.WIDTH(W), .CHANNELS(C)) bus ();
  max_pool_layer_if #(.WIDTH(16), .CHANNELS(1)) bus_a ();
  max_pool_layer_if #(.WIDTH(16), .CHANNELS(1)) bus_b ();

  max_pool_layer #(.WIDTH(W), .CHANNELS(C), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus));
  max_pool_layer #(.WIDTH(16), .CHANNELS(1), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2)) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus_a));
  max_pool_layer #(.WIDTH(16), .CHANNELS(1), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus_b));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic px_t pool4(input px_t a, input px_t b, input px_t c, input px_t d);
    px_t r;
    for (int ch = 0; ch < C; ch++) begin
      logic signed [W-1:0] m, v;
      m = a[ch*W +: W];
      v = b[ch*W +: W]; if (v > m) m = v;
      v = c[ch*W +: W]; if (v > m) m = v;
      v = d[ch*W +: W]; if (v > m) m = v;
`ifdef MAX_POOL_RELU_EN
      if (m < 0) m = '0;
`endif
      r[ch*W +: W] = m;
    end
    return r;
  endfunction

  // Streams the first npix pixels of a fresh random frame; expects only the blocks
  // whose bottom-right pixel is among those streamed.
  task automatic run_frame(input int npix, input bit rnd);
    px_t img [IH][IW];
    logic en, iv;
    int tries;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = px_t'({$urandom, $urandom, $urandom});
    for (int br = 0; br < IH / 2; br++)
      for (int bc = 0; bc < IW / 2; bc++)
        if ((2*br + 1) * IW + 2*bc + 1 < npix)
          q.push_back(pool4(img[2*br][2*bc], img[2*br][2*bc+1],
                            img[2*br+1][2*bc], img[2*br+1][2*bc+1]));
    for (int i = 0; i < npix; i++) begin
      tries = 0;
      do begin
        en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        iv = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        clk_en = en;
        bus.input_valid = iv;
        bus.input_data = iv ? img[i / IW][i % IW] : px_t'({$urandom, $urandom, $urandom});
        @(posedge clk);
        #1;
        tries++;
      end while (!(en && iv) && tries < 1000);
    end
    bus.input_valid = 1'b0;
    clk_en = 1'b1;
  endtask

  always @(posedge clk) en_last = clk_en;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      po = '0;
    end else begin
      if (!en_last) begin
        check("frozen_valid", bus.valid, pv);
        check("frozen_data", bus.output_data, po);
      end else if (bus.valid) begin
        if (q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL unexpected_valid: got valid with data %h, expected no output", bus.output_data);
        end else begin
          popped++;
          check("pooled", bus.output_data, q.pop_front());
        end
      end
      pv = bus.valid;
      po = bus.output_data;
    end
  end

  initial begin
    int pa[8] = '{1, 5, 2, 3, 4, 0, 7, 6};
    int pb[4] = '{-3, -8, -1, -9};
    int np, base;
    logic [15:0] eb;
`ifdef MAX_POOL_RELU_EN
    eb = 16'h0000;
`else
    eb = 16'hFFFF;
`endif
    rst = 1'b1;
    clk_en = 1'b1;
    bus.input_valid = 1'b0;   bus.input_data = '0;
    bus_a.input_valid = 1'b0; bus_a.input_data = '0;
    bus_b.input_valid = 1'b0; bus_b.input_data = '0;
    #2;
    check("rst_valid", bus.valid, 0);
    check("rst_data", bus.output_data, 0);
    check("rst_valid_a", bus_a.valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    np = 0;
    for (int i = 0; i < 8; i++) begin
      bus_a.input_data = 16'(pa[i]);
      bus_a.input_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("a_valid", bus_a.valid, (i == 5 || i == 7));
      if (bus_a.valid) begin
        np++;
        check("a_data", bus_a.output_data, i == 5 ? 16'd5 : 16'd7);
      end
    end
    bus_a.input_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("a_valid_drop", bus_a.valid, 0);
    check("a_hold", bus_a.output_data, 16'd7);
    check("a_pulses", np, 2);

    for (int i = 0; i < 4; i++) begin
      bus_b.input_data = 16'(pb[i]);
      bus_b.input_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("b_valid", bus_b.valid, i == 3);
    end
    check("b_data", bus_b.output_data, eb);
    bus_b.input_valid = 1'b0;

    @(posedge clk);
    #1;
    base = popped;
    run_frame(IW * IH, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("frame_full_rate", popped - base, 21);

    base = popped;
    run_frame(IW * IH, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("frame_toggled", popped - base, 21);

    base = popped;
    run_frame(21, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", bus.valid, 0);
    check("midrst_data", bus.output_data, 0);
    check("partial_count", popped - base, 3);
    @(posedge clk);
    #1 rst = 1'b0;
    base = popped;
    run_frame(IW * IH, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("frame_after_rst", popped - base, 21);

    base = popped;
    run_frame(IW * IH, 1'b0);
    run_frame(IW * IH, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("back_to_back", popped - base, 42);
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
